motion_search_engine: RTL and testbench



---
 rtl/motion_search_engine_pkg.sv | 49 ++++
 rtl/motion_search_engine_if.sv | 36 +++
 rtl/motion_search_engine_sae_unit.sv | 33 +++
 rtl/motion_search_engine.sv | 176 +++++++++++++++++
 tb/tb_motion_search_engine.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motion_search_engine_pkg.sv
// Shared definitions for the full-search block-matching engine.
//   - state_t   : transaction FSM states (IDLE / SEARCH / DONE)
//   - clog2     : ceiling log2 usable in constant expressions
//   - width helpers and the derived widths for the default configuration
//     (BLOCK_WIDTH=4, SEARCH_RANGE=2, WORD_SIZE=8)
// Optional build macro used by the engine: MOTION_SEARCH_EARLY_EXIT_EN.
package motion_search_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    function automatic int win_width(input int block_width, input int search_range);
        return block_width + 2 * search_range;
    endfunction

    // Worst-case SAE is BLOCK_WIDTH^2 * (2^WORD_SIZE - 1), which always fits here.
    function automatic int sae_width(input int block_width, input int word_size);
        return word_size + clog2(block_width * block_width);
    endfunction

    function automatic int mv_width(input int search_range);
        return clog2(search_range + 1) + 1;
    endfunction

    function automatic int num_cand(input int search_range);
        return (2 * search_range + 1) * (2 * search_range + 1);
    endfunction

    localparam int WIN_WIDTH = win_width(4, 2);
    localparam int SAE_W     = sae_width(4, 8);
    localparam int MV_W      = mv_width(2);
    localparam int N         = num_cand(2);

endpackage

// File: rtl/motion_search_engine_if.sv
// Request/result bus of the motion search engine.
//   in_valid/in_ready   : request handshake carrying block_a and search_win
//   out_valid/out_ready : result handshake carrying mv_x, mv_y, min_sae
// Modports: master = requester/consumer side, slave = engine side.
interface motion_search_engine_if #(
    parameter int BLOCK_WIDTH  = 4,
    parameter int SEARCH_RANGE = 2,
    parameter int WORD_SIZE    = 8
);
    import motion_search_pkg::*;

    localparam int WIN_W    = win_width(BLOCK_WIDTH, SEARCH_RANGE);
    localparam int SAE_BITS = sae_width(BLOCK_WIDTH, WORD_SIZE);
    localparam int MV_BITS  = mv_width(SEARCH_RANGE);

    logic                                         in_valid;
    logic                                         in_ready;
    logic [BLOCK_WIDTH*BLOCK_WIDTH*WORD_SIZE-1:0] block_a;
    logic [WIN_W*WIN_W*WORD_SIZE-1:0]             search_win;
    logic                                         out_valid;
    logic                                         out_ready;
    logic signed [MV_BITS-1:0]                    mv_x;
    logic signed [MV_BITS-1:0]                    mv_y;
    logic [SAE_BITS-1:0]                          min_sae;

    modport master (
        output in_valid, block_a, search_win, out_ready,
        input  in_ready, out_valid, mv_x, mv_y, min_sae
    );

    modport slave (
        input  in_valid, block_a, search_win, out_ready,
        output in_ready, out_valid, mv_x, mv_y, min_sae
    );

endinterface

// File: rtl/motion_search_engine_sae_unit.sv
// sae_unit: combinational sum of absolute differences over BLOCK_WIDTH^2
// pixel pairs.
//   block_a, block_b : packed pixel arrays, pixel i at [WORD_SIZE*i +: WORD_SIZE]
//   sae              : sum of |a_i - b_i|, SAE_W bits wide (cannot overflow)
module sae_unit
    import motion_search_pkg::*;
#(
    parameter int BLOCK_WIDTH = 4,
    parameter int WORD_SIZE   = 8,
    parameter int SAE_W       = sae_width(BLOCK_WIDTH, WORD_SIZE)
) (
    input  logic [BLOCK_WIDTH*BLOCK_WIDTH*WORD_SIZE-1:0] block_a,
    input  logic [BLOCK_WIDTH*BLOCK_WIDTH*WORD_SIZE-1:0] block_b,
    output logic [SAE_W-1:0]                             sae
);

    localparam int PIX = BLOCK_WIDTH * BLOCK_WIDTH;

    function automatic logic [WORD_SIZE-1:0] abs_diff(input logic [WORD_SIZE-1:0] x,
                                                      input logic [WORD_SIZE-1:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    // Accumulate every pixel-pair difference; synthesis flattens this into an adder tree.
    always_comb begin
        sae = '0;
        for (int i = 0; i < PIX; i++) begin
            sae = sae + SAE_W'(abs_diff(block_a[i*WORD_SIZE +: WORD_SIZE],
                                        block_b[i*WORD_SIZE +: WORD_SIZE]));
        end
    end

endmodule

// File: rtl/motion_search_engine.sv
// motion_search_engine: sequential full-search block matcher. One request
// (current block + search window) is accepted, every displacement in
// [-SEARCH_RANGE, +SEARCH_RANGE]^2 is scored one per clock through a single
// sae_unit, and the lowest SAE with its motion vector is returned.
//   clk, rst : clock and synchronous active-high reset
//   bus      : motion_search_engine_if.slave (request and result handshakes)
// Optional build macro: MOTION_SEARCH_EARLY_EXIT_EN -- finish as soon as a
// candidate scores SAE 0.
module motion_search_engine #(
    parameter int BLOCK_WIDTH  = 4,
    parameter int SEARCH_RANGE = 2,
    parameter int WORD_SIZE    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    motion_search_engine_if.slave   bus
);
    import motion_search_pkg::*;

    localparam int PIX      = BLOCK_WIDTH * BLOCK_WIDTH;
    localparam int WIN_W    = win_width(BLOCK_WIDTH, SEARCH_RANGE);
    localparam int SAE_BITS = sae_width(BLOCK_WIDTH, WORD_SIZE);
    localparam int MV_BITS  = mv_width(SEARCH_RANGE);
    localparam int NUM_CAND = num_cand(SEARCH_RANGE);
    localparam int IDX_W    = (NUM_CAND > 1) ? clog2(NUM_CAND) : 1;

    localparam logic signed [MV_BITS-1:0] MV_LO    = MV_BITS'(-SEARCH_RANGE);
    localparam logic signed [MV_BITS-1:0] MV_HI    = MV_BITS'(SEARCH_RANGE);
    localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(NUM_CAND - 1);

    state_t                       state;
    state_t                       next_state;
    logic [PIX*WORD_SIZE-1:0]     blk_reg;
    logic [PIX*WORD_SIZE-1:0]     cand_blk;
    logic [WIN_W*WIN_W*WORD_SIZE-1:0] win_reg;
    logic [IDX_W-1:0]             cand_idx;
    logic signed [MV_BITS-1:0]    cur_dx;
    logic signed [MV_BITS-1:0]    cur_dy;
    logic signed [MV_BITS-1:0]    best_dx;
    logic signed [MV_BITS-1:0]    best_dy;
    logic signed [MV_BITS-1:0]    held_dx;
    logic signed [MV_BITS-1:0]    held_dy;
    logic [SAE_BITS-1:0]          cand_sae;
    logic [SAE_BITS-1:0]          best_sae;
    logic [SAE_BITS-1:0]          held_sae;
    logic                         better;
    logic                         last_cand;

    // Slice the candidate sub-block at window offset (dy+R, dx+R) out of the stored window.
    always_comb begin
        cand_blk = '0;
        for (int r = 0; r < BLOCK_WIDTH; r++) begin
            for (int c = 0; c < BLOCK_WIDTH; c++) begin
                cand_blk[(r*BLOCK_WIDTH + c)*WORD_SIZE +: WORD_SIZE] =
                    win_reg[((r + int'(cur_dy) + SEARCH_RANGE)*WIN_W
                             + c + int'(cur_dx) + SEARCH_RANGE)*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    sae_unit #(
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .WORD_SIZE   (WORD_SIZE),
        .SAE_W       (SAE_BITS)
    ) u_sae (
        .block_a (blk_reg),
        .block_b (cand_blk),
        .sae     (cand_sae)
    );

    // Strict compare keeps the earliest candidate in raster order on ties.
    assign better    = cand_sae < best_sae;
    assign last_cand = cand_idx == LAST_IDX;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs. in_ready and out_valid are decoded from
    // distinct states, so they can never be high together.
    always_comb begin
        next_state    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    next_state = SEARCH;
                end
            end
            SEARCH: begin
                if (last_cand) begin
                    next_state = DONE;
                end
`ifdef MOTION_SEARCH_EARLY_EXIT_EN
                if (cand_sae == '0) begin
                    next_state = DONE;
                end
`endif
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: capture the request, walk the candidates in raster order (dx inner),
    // track the best one, and latch it into the hold registers while in DONE so the
    // outputs keep the last result through IDLE and the next SEARCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_reg  <= '0;
            win_reg  <= '0;
            cand_idx <= '0;
            cur_dx   <= '0;
            cur_dy   <= '0;
            best_dx  <= '0;
            best_dy  <= '0;
            best_sae <= '0;
            held_dx  <= '0;
            held_dy  <= '0;
            held_sae <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        blk_reg  <= bus.block_a;
                        win_reg  <= bus.search_win;
                        cand_idx <= '0;
                        cur_dx   <= MV_LO;
                        cur_dy   <= MV_LO;
                        best_sae <= '1;
                    end
                end
                SEARCH: begin
                    if (better) begin
                        best_sae <= cand_sae;
                        best_dx  <= cur_dx;
                        best_dy  <= cur_dy;
                    end
                    cand_idx <= cand_idx + 1'b1;
                    if (cur_dx == MV_HI) begin
                        cur_dx <= MV_LO;
                        cur_dy <= cur_dy + MV_BITS'(1);
                    end else begin
                        cur_dx <= cur_dx + MV_BITS'(1);
                    end
                end
                DONE: begin
                    held_dx  <= best_dx;
                    held_dy  <= best_dy;
                    held_sae <= best_sae;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mv_x    = (state == DONE) ? best_dx  : held_dx;
    assign bus.mv_y    = (state == DONE) ? best_dy  : held_dy;
    assign bus.min_sae = (state == DONE) ? best_sae : held_sae;

endmodule

// File: tb/tb_motion_search_engine.sv
// Self-checking bench for motion_search_engine with default parameters.
// Directed table vectors with hand-derived results, multi-cycle sequences
// (backpressure, resets mid-transaction, reset colliding with a request),
// then random requests scored against a direct full-search model.
// Honours MOTION_SEARCH_EARLY_EXIT_EN when computing expected latency.
module tb_motion_search_engine;
    import motion_search_pkg::*;

    localparam int BW  = 4;
    localparam int R   = 2;
    localparam int WS  = 8;
    localparam int WIN = win_width(BW, R);
    localparam int NC  = num_cand(R);

    typedef logic [BW*BW*WS-1:0]   blk_t;
    typedef logic [WIN*WIN*WS-1:0] win_t;

    typedef struct {
        string name;
        blk_t  blk;
        win_t  win;
        int    exp_dx;
        int    exp_dy;
        int    exp_sae;
        int    zero_idx;
    } vec_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    vec_t vecs[5];

    motion_search_engine_if #(.BLOCK_WIDTH(BW), .SEARCH_RANGE(R), .WORD_SIZE(WS)) bus ();

    motion_search_engine #(
        .BLOCK_WIDTH  (BW),
        .SEARCH_RANGE (R),
        .WORD_SIZE    (WS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a handshake never completes.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1, "[TB] timeout");
    end

    function automatic blk_t blk_set(input blk_t b, input int r, input int c, input int v);
        b[WS*(r*BW + c) +: WS] = WS'(v);
        return b;
    endfunction

    function automatic win_t win_set(input win_t w, input int r, input int c, input int v);
        w[WS*(r*WIN + c) +: WS] = WS'(v);
        return w;
    endfunction

    function automatic int blk_px(input blk_t b, input int r, input int c);
        return int'(b[WS*(r*BW + c) +: WS]);
    endfunction

    function automatic int win_px(input win_t w, input int r, input int c);
        return int'(w[WS*(r*WIN + c) +: WS]);
    endfunction

    function automatic int exp_latency(input int zero_idx);
`ifdef MOTION_SEARCH_EARLY_EXIT_EN
        if (zero_idx >= 0) return zero_idx + 2;
`endif
        return NC + 1;
    endfunction

    // Reference: score every displacement directly and keep the first minimum.
    function automatic void model(input blk_t b, input win_t w,
                                  output int ex, output int ey, output int es, output int elat);
        int idx;
        int s;
        int d;
        bit stop;
        idx  = 0;
        stop = 1'b0;
        es   = -1;
        ex   = 0;
        ey   = 0;
        elat = NC + 1;
        for (int dy = -R; dy <= R; dy++) begin
            for (int dx = -R; dx <= R; dx++) begin
                if (!stop) begin
                    s = 0;
                    for (int r = 0; r < BW; r++) begin
                        for (int c = 0; c < BW; c++) begin
                            d = blk_px(b, r, c) - win_px(w, r + dy + R, c + dx + R);
                            s += (d < 0) ? -d : d;
                        end
                    end
                    if (es < 0 || s < es) begin
                        es = s;
                        ex = dx;
                        ey = dy;
                    end
`ifdef MOTION_SEARCH_EARLY_EXIT_EN
                    if (s == 0) begin
                        stop = 1'b1;
                        elat = idx + 2;
                    end
`endif
                    idx++;
                end
            end
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Present a request and return at the first negedge after the handshake edge.
    task automatic startRequest(input string name, input blk_t b, input win_t w);
        int guard;
        @(negedge clk);
        bus.block_a    = b;
        bus.search_win = w;
        bus.in_valid   = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({name, "_accept"}, int'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.block_a    = {4{$urandom()}};
        bus.search_win = {16{$urandom()}};
    endtask

    task automatic waitResult(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic releaseResult();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic applyStimulus(input string name, input blk_t b, input win_t w,
                                 input int ex, input int ey, input int es, input int elat,
                                 input int stall);
        int lat;
        startRequest(name, b, w);
        waitResult(lat);
        checkOutput({name, "_latency"}, lat, elat);
        repeat (stall) @(negedge clk);
        checkOutput({name, "_mv_x"}, $signed(bus.mv_x), ex);
        checkOutput({name, "_mv_y"}, $signed(bus.mv_y), ey);
        checkOutput({name, "_min_sae"}, int'(bus.min_sae), es);
        releaseResult();
        checkOutput({name, "_valid_drop"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        blk_t b;
        win_t w;
        int   ex, ey, es, elat, lat, seen;

        compared      = 0;
        mismatched    = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.block_a   = '0;
        bus.search_win = '0;

        // Uniform 0x10: every candidate scores 0, the first (-2,-2) wins.
        vecs[0].name = "flat";
        vecs[0].blk = {(BW*BW){8'h10}};
        vecs[0].win = {(WIN*WIN){8'h10}};
        vecs[0].exp_dx = -2; vecs[0].exp_dy = -2; vecs[0].exp_sae = 0; vecs[0].zero_idx = 0;

        // Ramp copied at (dy=+1, dx=+2) into a zero window.
        b = '0;
        for (int r = 0; r < BW; r++)
            for (int c = 0; c < BW; c++) b = blk_set(b, r, c, 16*r + c + 1);
        w = '0;
        for (int r = 0; r < BW; r++)
            for (int c = 0; c < BW; c++) w = win_set(w, r + 3, c + 4, blk_px(b, r, c));
        vecs[1].name = "ramp";
        vecs[1].blk = b; vecs[1].win = w;
        vecs[1].exp_dx = 2; vecs[1].exp_dy = 1; vecs[1].exp_sae = 0; vecs[1].zero_idx = 19;

        // Same ramp at (0,0): the centre candidate, raster index 12.
        w = '0;
        for (int r = 0; r < BW; r++)
            for (int c = 0; c < BW; c++) w = win_set(w, r + 2, c + 2, blk_px(b, r, c));
        vecs[2].name = "centre";
        vecs[2].blk = b; vecs[2].win = w;
        vecs[2].exp_dx = 0; vecs[2].exp_dy = 0; vecs[2].exp_sae = 0; vecs[2].zero_idx = 12;

        // Tie: rows alternate 0/100, columns step by 20; (-1,0) and (+1,0) both score 16.
        b = '0;
        for (int r = 0; r < BW; r++)
            for (int c = 0; c < BW; c++) b = blk_set(b, r, c, 20*(c + 2) + ((r % 2 == 0) ? 101 : 1));
        w = '0;
        for (int y = 0; y < WIN; y++)
            for (int x = 0; x < WIN; x++) w = win_set(w, y, x, 20*x + ((y % 2 == 1) ? 100 : 0));
        vecs[3].name = "tie";
        vecs[3].blk = b; vecs[3].win = w;
        vecs[3].exp_dx = 0; vecs[3].exp_dy = -1; vecs[3].exp_sae = 16; vecs[3].zero_idx = -1;

        // Saturated difference: 16 * 255 needs the full 12-bit SAE.
        vecs[4].name = "max_sae";
        vecs[4].blk = {(BW*BW){8'hFF}};
        vecs[4].win = '0;
        vecs[4].exp_dx = -2; vecs[4].exp_dy = -2; vecs[4].exp_sae = 4080; vecs[4].zero_idx = -1;

        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", int'(bus.in_ready), 1);
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_mv_x", $signed(bus.mv_x), 0);
        checkOutput("reset_mv_y", $signed(bus.mv_y), 0);
        checkOutput("reset_min_sae", int'(bus.min_sae), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].name, vecs[i].blk, vecs[i].win, vecs[i].exp_dx,
                          vecs[i].exp_dy, vecs[i].exp_sae, exp_latency(vecs[i].zero_idx), 0);
        end

        // Backpressure: result must hold for 10 stalled cycles, then the engine reopens.
        startRequest("bp", vecs[1].blk, vecs[1].win);
        waitResult(lat);
        checkOutput("bp_latency", lat, exp_latency(vecs[1].zero_idx));
        for (int k = 0; k < 10; k++) begin
            checkOutput("bp_out_valid", int'(bus.out_valid), 1);
            checkOutput("bp_in_ready", int'(bus.in_ready), 0);
            checkOutput("bp_mv_x", $signed(bus.mv_x), 2);
            checkOutput("bp_mv_y", $signed(bus.mv_y), 1);
            checkOutput("bp_min_sae", int'(bus.min_sae), 0);
            @(negedge clk);
        end
        releaseResult();
        checkOutput("bp_after_out_valid", int'(bus.out_valid), 0);
        checkOutput("bp_after_in_ready", int'(bus.in_ready), 1);
        checkOutput("bp_hold_mv_x", $signed(bus.mv_x), 2);
        applyStimulus("bp_next", vecs[3].blk, vecs[3].win, 0, -1, 16, NC + 1, 0);

        // Reset while candidate 12 is being scored: prior result (tie) must be cleared.
        startRequest("rst_search", vecs[4].blk, vecs[4].win);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_search_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_search_in_ready", int'(bus.in_ready), 1);
        checkOutput("rst_search_min_sae", int'(bus.min_sae), 0);
        checkOutput("rst_search_mv_y", $signed(bus.mv_y), 0);
        applyStimulus("rst_search_next", vecs[3].blk, vecs[3].win, 0, -1, 16, NC + 1, 0);

        // Reset while a result is stalled in DONE.
        startRequest("rst_done", vecs[4].blk, vecs[4].win);
        waitResult(lat);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_done_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_done_min_sae", int'(bus.min_sae), 0);

        // Reset and request in the same cycle: the request must be dropped.
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.block_a = vecs[4].blk;
        bus.search_win = vecs[4].win;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < NC + 4; k++) begin
            if (bus.out_valid) seen++;
            @(negedge clk);
        end
        checkOutput("rst_collide_results", seen, 0);
        checkOutput("rst_collide_in_ready", int'(bus.in_ready), 1);

        // Random requests, half with a narrow pixel range to provoke ties and zeros.
        for (int t = 0; t < 10; t++) begin
            int maxv;
            maxv = (t % 2 == 0) ? 3 : 255;
            b = '0;
            w = '0;
            for (int i = 0; i < BW*BW; i++) b[WS*i +: WS] = WS'($urandom_range(maxv, 0));
            for (int i = 0; i < WIN*WIN; i++) w[WS*i +: WS] = WS'($urandom_range(maxv, 0));
            model(b, w, ex, ey, es, elat);
            applyStimulus($sformatf("rand%0d", t), b, w, ex, ey, es, elat, int'($urandom_range(3, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
